alu_ctrl_fsm: RTL and testbench
===============================

# alu_ctrl_fsm

Multi-cycle fetch/decode/execute controller that drives the processor's combinational ALU. It fetches 9-bit instructions from a synchronous instruction ROM and decodes them into ALU function codes, register-file read/write controls and immediates. It consumes the ALU's `takeBranch` output to resolve conditional branches. It sits between the instruction ROM, the register file and the ALU, and owns the program counter.

## Interface
Parameters:
- `PC_W`, default 8: program counter / instruction address width.

Ports:
- `Clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `Reset`: input, 1 bit. Synchronous, active-high.
- `Start`: input, 1 bit. Begins execution from PC 0; sampled only in IDLE or HALT.
- `InstIn`: input, 9 bits. ROM data; valid one cycle after `InstAddr` is presented.
- `takeBranch`: input, 1 bit. ALU branch result, sampled in EXEC.
- `InstAddr`: output, PC_W bits. ROM address; equals the current PC.
- `AluFunc`: output, 3 bits. ALU function code: kADD, kOR, kXOR, kAND, kLT, kEQ, kSLL or kSRL.
- `RdAddrB`: output, 3 bits. Register-file read address for ALU InputB. InputA is always R0.
- `WrAddr`: output, 3 bits. Register-file write address.
- `WrEn`: output, 1 bit. Register-file write strobe; high for exactly one cycle.
- `WrSel`: output, 1 bit. Write-data select: 0 selects ALU Out, 1 selects `Imm`.
- `Imm`: output, 8 bits. Zero-extended immediate.
- `Busy`: output, 1 bit. High in FETCH, DECODE, EXEC and WB.
- `Done`: output, 1 bit. High while in HALT.
- `RetCount`: output, 16 bits. Count of retired instructions; saturates at 16'hFFFF.

## Operation
Instruction format, with IR[8:0] as the latched instruction:
- **IR[8]=0, R-type:** `AluFunc`=IR[7:5], `RdAddrB`=IR[4:2], `WrAddr`={1'b0,IR[1:0]}, `WrSel`=0.
- **IR[8:6]=100, LI:** R0 <= {2'b0,IR[5:0]}. `WrAddr`=0, `WrSel`=1.
- **IR[8:6]=101, BR:** if the branch flag is 1, PC <= PC + sign-extended IR[5:0]; otherwise PC+1.
- **IR[8:6]=110, JMP:** PC <= zero-extended IR[5:0].
- **IR[8:6]=111, HALT:** enter HALT. IR[5:0] is ignored.

States and transitions:
- **IDLE:** reset state. Moves to FETCH when `Start`=1; PC is cleared to 0.
- **FETCH:** presents `InstAddr`=PC. Always moves to DECODE.
- **DECODE:** IR <= `InstIn`. Moves to EXEC.
- **EXEC:** drives `AluFunc` and `RdAddrB` from IR.
  - For R-type only, branch flag <= `takeBranch`.
  - Moves to WB, or to HALT if IR is HALT.
- **WB:** pulses `WrEn` for R-type and LI, then updates PC per the instruction.
  - BR and JMP do not write.
  - `RetCount` increments. Moves to FETCH.
- **HALT:** `Done`=1. On `Start`=1: PC <= 0, branch flag <= 0, move to FETCH.

Arithmetic and width rules:
- PC arithmetic is modulo 2^PC_W. PC+1 at the maximum address wraps to 0, and branch targets wrap in both directions.
- HALT counts as retired: `RetCount` increments on the EXEC to HALT transition.
- `RetCount` clears only on `Reset`; it is not cleared by `Start`.

Boundary conditions:
- The branch flag persists across LI, BR and JMP; only R-type instructions update it.
- `Start` asserted while `Busy` is ignored.
- `AluFunc`, `RdAddrB`, `WrAddr`, `WrSel` and `Imm` hold their IR-derived values in EXEC and WB. In all other states they are 0.

## Timing
- Every instruction takes exactly 4 cycles (FETCH, DECODE, EXEC, WB). HALT takes 3 cycles to reach the HALT state.
- `WrEn` is registered and high only during the WB cycle. The register file writes on the Clk edge that ends WB.
- ALU operands are stable throughout EXEC and WB. ALU Out is valid in WB for the write.
- `takeBranch` is sampled on the Clk edge that ends EXEC.
- Reset values: state IDLE, PC 0, IR 0, branch flag 0. All outputs are 0: `InstAddr`, `AluFunc`, `RdAddrB`, `WrAddr`, `WrEn`, `WrSel`, `Imm`, `Busy`, `Done`, `RetCount`.
- `Reset` asserted in any state, including WB, takes effect on that edge. The state returns to IDLE, no `WrEn` pulse follows, and the PC is not updated.
- `Start` and `Reset` asserted together: `Reset` wins.

## Test plan
- Reset, then `Start` with ROM[0]=LI 5 (9'h105). Expect `InstAddr`=0 in FETCH and `WrEn`=1 in cycle 4 with `WrAddr`=0, `WrSel`=1, `Imm`=8'h05. `RetCount`=1 afterwards.
- ROM[1]=R-type kEQ with rs=R1, rd=R2, and a model ALU returning `takeBranch`=1. Expect `AluFunc`=kEQ, `RdAddrB`=1, `WrAddr`=2 during EXEC and WB.
- Continuing from that test, ROM[2]=BR -2 (9'h17E). Expect the next FETCH at `InstAddr`=0. With `takeBranch`=0 on the prior R-type instead, expect the next FETCH at `InstAddr`=3.
- JMP 63 at PC 255 (PC_W=8) followed by a BR +1 with the flag clear. Expect the next fetch addresses 63 then 64. Separately, a non-branch instruction at PC 255 must lead to a next fetch at 0.
- HALT at PC 4. Expect `Done`=1 and `Busy`=0 three cycles after its FETCH, and `RetCount` incremented. `Start` then gives a FETCH at `InstAddr`=0. `Start` pulsed mid-program is ignored.
- Assert `Reset` during a WB cycle of an R-type instruction. On the next cycle expect state IDLE, all outputs 0, and no `WrEn` pulse observed.

Source files
------------

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle fetch/decode/execute controller for the ALU datapath.
// Owns the PC, latches 9-bit instructions from a synchronous ROM and drives
// ALU function, register-file and immediate controls, four cycles per instruction.
module alu_ctrl_fsm #(
  parameter int PC_W = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [8:0]      InstIn,
  input  logic            takeBranch,
  output logic [PC_W-1:0] InstAddr,
  output logic [2:0]      AluFunc,
  output logic [2:0]      RdAddrB,
  output logic [2:0]      WrAddr,
  output logic            WrEn,
  output logic            WrSel,
  output logic [7:0]      Imm,
  output logic            Busy,
  output logic            Done,
  output logic [15:0]     RetCount
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_e;

  // Major opcodes in IR[8:6]; anything with IR[8]=0 is R-type.
  localparam logic [2:0] OP_LI   = 3'b100;
  localparam logic [2:0] OP_BR   = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_e          state;
  logic [PC_W-1:0] pc;
  logic [8:0]      ir;
  logic            br_flag;

  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] jmp_tgt;

  // Branch offset is sign-extended, jump target zero-extended, both to PC width.
  assign br_off   = {{(PC_W-6){ir[5]}}, ir[5:0]};
  assign jmp_tgt  = {{(PC_W-6){1'b0}}, ir[5:0]};
  assign InstAddr = pc;

  // Controller state, PC, IR, branch flag and all registered outputs.
  // NOTE: every register here uses <= so all reads see pre-edge values,
  // which is what lets WB use the old pc and br_flag in the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: reset is synchronous; it is just the highest-priority branch
      // of the clocked block, so Reset also beats a simultaneous Start.
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      br_flag  <= 1'b0;
      AluFunc  <= '0;
      RdAddrB  <= '0;
      WrAddr   <= '0;
      WrEn     <= 1'b0;
      WrSel    <= 1'b0;
      Imm      <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      RetCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            pc    <= '0;
            Busy  <= 1'b1;
            state <= FETCH;
          end
        end

        FETCH: begin
          // ROM sees pc this cycle and returns the word during DECODE.
          state <= DECODE;
        end

        DECODE: begin
          ir      <= InstIn;
          AluFunc <= '0;
          RdAddrB <= '0;
          WrAddr  <= '0;
          WrSel   <= 1'b0;
          Imm     <= '0;
          if (!InstIn[8]) begin
            AluFunc <= InstIn[7:5];
            RdAddrB <= InstIn[4:2];
            WrAddr  <= {1'b0, InstIn[1:0]};
          end else if (InstIn[8:6] == OP_LI) begin
            WrSel <= 1'b1;
            Imm   <= {2'b00, InstIn[5:0]};
          end else if (InstIn[8:6] != OP_HALT) begin
            Imm <= {2'b00, InstIn[5:0]};
          end
          state <= EXEC;
        end

        EXEC: begin
          if (!ir[8]) begin
            br_flag <= takeBranch;
          end
          if (ir[8:6] == OP_HALT) begin
            AluFunc <= '0;
            RdAddrB <= '0;
            WrAddr  <= '0;
            WrSel   <= 1'b0;
            Imm     <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            if (RetCount != 16'hFFFF) begin
              RetCount <= RetCount + 16'd1;
            end
            state <= HALT;
          end else begin
            WrEn  <= !ir[8] || (ir[8:6] == OP_LI);
            state <= WB;
          end
        end

        WB: begin
          WrEn    <= 1'b0;
          AluFunc <= '0;
          RdAddrB <= '0;
          WrAddr  <= '0;
          WrSel   <= 1'b0;
          Imm     <= '0;
          if (RetCount != 16'hFFFF) begin
            RetCount <= RetCount + 16'd1;
          end
          case (ir[8:6])
            OP_BR:   pc <= br_flag ? pc + br_off : pc + PC_W'(1);
            OP_JMP:  pc <= jmp_tgt;
            default: pc <= pc + PC_W'(1);
          endcase
          state <= FETCH;
        end

        HALT: begin
          if (Start) begin
            pc      <= '0;
            br_flag <= 1'b0;
            Done    <= 1'b0;
            Busy    <= 1'b1;
            state   <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: directed and randomized program runs against an
// instruction-level reference model of the controller.
module tb_alu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        take_branch;
  logic [8:0]  inst_in;
  logic [7:0]  inst_addr;
  logic [2:0]  alu_func;
  logic [2:0]  rd_addr_b;
  logic [2:0]  wr_addr;
  logic        wr_en;
  logic        wr_sel;
  logic [7:0]  imm;
  logic        busy;
  logic        done;
  logic [15:0] ret_count;

  always #5 clk = ~clk;

  alu_ctrl_fsm #(.PC_W(8)) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Start     (start),
    .InstIn    (inst_in),
    .takeBranch(take_branch),
    .InstAddr  (inst_addr),
    .AluFunc   (alu_func),
    .RdAddrB   (rd_addr_b),
    .WrAddr    (wr_addr),
    .WrEn      (wr_en),
    .WrSel     (wr_sel),
    .Imm       (imm),
    .Busy      (busy),
    .Done      (done),
    .RetCount  (ret_count)
  );

  // Synchronous instruction ROM: one cycle of read latency.
  logic [8:0] rom [256];
  always @(posedge clk) inst_in <= rom[inst_addr];

  int errors = 0;
  int checks = 0;

  // Reference model state at instruction granularity.
  int m_pc   = 0;
  bit m_flag = 1'b0;
  int m_ret  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fields();
    return 32'({alu_func, rd_addr_b, wr_addr, wr_sel, imm});
  endfunction

  // Start and takeBranch wiggle randomly whenever the DUT must ignore them.
  task automatic drive_noise();
    start       = 1'($urandom_range(0, 1));
    take_branch = 1'($urandom_range(0, 1));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_addr"}, 32'(inst_addr), 32'd0);
    check({tag, "_fields"}, fields(), 32'd0);
    check({tag, "_wren"}, 32'(wr_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ret"}, 32'(ret_count), 32'd0);
  endtask

  task automatic check_fields(input string tag, input logic [8:0] i);
    if (!i[8]) begin
      check({tag, "_alufunc"}, 32'(alu_func), 32'(i[7:5]));
      check({tag, "_rdaddrb"}, 32'(rd_addr_b), 32'(i[4:2]));
      check({tag, "_wraddr"}, 32'(wr_addr), 32'(i[1:0]));
      check({tag, "_wrsel"}, 32'(wr_sel), 32'd0);
    end else if (i[8:6] == 3'b100) begin
      check({tag, "_wraddr"}, 32'(wr_addr), 32'd0);
      check({tag, "_wrsel"}, 32'(wr_sel), 32'd1);
      check({tag, "_imm"}, 32'(imm), 32'(i[5:0]));
    end
  endtask

  // Start a run from IDLE or HALT; called on a falling edge.
  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    m_pc   = 0;
    m_flag = 1'b0;
  endtask

  // Run one instruction from its FETCH cycle to the next FETCH (or HALT).
  // tb_force < 0 lets the model ALU pick takeBranch at random.
  task automatic exec_one(input int tb_force, output bit halted);
    logic [8:0] i;
    bit         tb;
    bit         is_r;
    bit         is_li;
    int         off;
    i      = rom[m_pc];
    is_r   = !i[8];
    is_li  = (i[8:6] == 3'b100);
    halted = 1'b0;

    check("fetch_addr", 32'(inst_addr), 32'(m_pc));
    check("fetch_busy", 32'(busy), 32'd1);
    check("fetch_done", 32'(done), 32'd0);
    check("fetch_fields", fields(), 32'd0);
    drive_noise();
    @(negedge clk);  // DECODE
    check("decode_fields", fields(), 32'd0);
    check("decode_wren", 32'(wr_en), 32'd0);
    drive_noise();
    @(negedge clk);  // EXEC
    check_fields("exec", i);
    check("exec_wren", 32'(wr_en), 32'd0);
    tb          = (tb_force < 0) ? 1'($urandom_range(0, 1)) : 1'(tb_force);
    take_branch = tb;
    if (i[8:6] == 3'b111) begin
      start = 1'b0;
      @(negedge clk);  // HALT
      if (m_ret < 65535) m_ret++;
      check("halt_done", 32'(done), 32'd1);
      check("halt_busy", 32'(busy), 32'd0);
      check("halt_fields", fields(), 32'd0);
      check("halt_ret", 32'(ret_count), 32'(m_ret));
      halted = 1'b1;
      return;
    end
    start = 1'($urandom_range(0, 1));
    @(negedge clk);  // WB
    check("wb_wren", 32'(wr_en), 32'(is_r || is_li));
    check_fields("wb", i);
    check("wb_busy", 32'(busy), 32'd1);
    if (is_r) m_flag = tb;
    case (i[8:6])
      3'b101: begin
        off = int'(i[5:0]) - (i[5] ? 64 : 0);
        m_pc = m_flag ? (m_pc + off + 256) % 256 : (m_pc + 1) % 256;
      end
      3'b110:  m_pc = int'(i[5:0]);
      default: m_pc = (m_pc + 1) % 256;
    endcase
    if (m_ret < 65535) m_ret++;
    drive_noise();
    @(negedge clk);  // next FETCH
    check("retire_count", 32'(ret_count), 32'(m_ret));
  endtask

  initial begin
    bit h;
    reset       = 1'b1;
    start       = 1'b0;
    take_branch = 1'b0;
    for (int k = 0; k < 256; k++) rom[k] = 9'h000;

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset");

    // Reset and Start in the same cycle: Reset wins.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check_idle("rst_beats_start");

    // Program 1: LI 5; EQ R1->R2; BR -2; R-type; HALT at PC 4.
    rom[0] = 9'h105;
    rom[1] = 9'h0A6;
    rom[2] = 9'h17E;
    rom[3] = 9'h01F;
    rom[4] = 9'h1C0;
    start_run();
    check("first_fetch", 32'(inst_addr), 32'd0);
    exec_one(-1, h);
    check("li_retired", 32'(ret_count), 32'd1);
    exec_one(1, h);
    exec_one(-1, h);
    check("br_taken_target", 32'(inst_addr), 32'd0);
    exec_one(-1, h);
    exec_one(0, h);
    exec_one(-1, h);
    check("br_not_taken_target", 32'(inst_addr), 32'd3);
    exec_one(-1, h);
    exec_one(-1, h);
    check("halt_reached", 32'(h), 32'd1);
    check("halt_retcount", 32'(ret_count), 32'd8);
    start_run();
    check("restart_fetch", 32'(inst_addr), 32'd0);
    check("restart_keeps_ret", 32'(ret_count), 32'd8);

    // Program 2: reach 254, fall through to 255, JMP 63, BR +1 with flag clear.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ret = 0;
    for (int k = 0; k < 256; k++) rom[k] = 9'h000;
    rom[0]   = 9'h0A6;
    rom[1]   = 9'h17D;
    rom[254] = 9'h0A6;
    rom[255] = 9'h1BF;
    rom[63]  = 9'h141;
    rom[64]  = 9'h1C0;
    start_run();
    exec_one(1, h);
    exec_one(-1, h);
    check("br_back_wrap", 32'(inst_addr), 32'd254);
    exec_one(0, h);
    exec_one(-1, h);
    check("jmp_target", 32'(inst_addr), 32'd63);
    exec_one(-1, h);
    check("br_clear_flag", 32'(inst_addr), 32'd64);
    exec_one(-1, h);
    check("halt2_reached", 32'(h), 32'd1);

    // Program 3: non-branch at 255 wraps to 0, then Reset during WB.
    rom[1]   = 9'h17E;
    rom[255] = 9'h107;
    start_run();
    exec_one(1, h);
    exec_one(-1, h);
    exec_one(-1, h);
    check("pc_wrap_fetch", 32'(inst_addr), 32'd0);
    @(negedge clk);  // DECODE
    @(negedge clk);  // EXEC
    take_branch = 1'b1;
    @(negedge clk);  // WB
    check("pre_reset_wren", 32'(wr_en), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check_idle("reset_in_wb");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_reset_wren", 32'(wr_en), 32'd0);
      check("post_reset_busy", 32'(busy), 32'd0);
    end
    m_ret  = 0;
    m_flag = 1'b0;

    // Randomized programs, restarting on each HALT.
    for (int k = 0; k < 256; k++) rom[k] = 9'($urandom);
    start_run();
    for (int n = 0; n < 300; n++) begin
      exec_one(-1, h);
      if (h) start_run();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
